// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: scan-out reads preempt buffered writer pushes, which drain during blanking.
// Optional drop statistics output enabled by defining FB_PORT_ARBITER_STATS_EN.
module fb_port_arbiter #(
  parameter int A_SIZE     = 8,
  parameter int P_SIZE     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blanking,
  input  logic [A_SIZE-1:0] scan_addr,
  input  logic              wr_req,
  input  logic [A_SIZE-1:0] wr_addr,
  input  logic [P_SIZE-1:0] wr_data,
  output logic              wr_ready,
  output logic [A_SIZE-1:0] mem_addr,
  output logic              mem_we,
  output logic [P_SIZE-1:0] mem_wdata,
  input  logic [P_SIZE-1:0] mem_rdata,
  output logic [P_SIZE-1:0] pix_data,
  output logic              pix_valid
`ifdef FB_PORT_ARBITER_STATS_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [A_SIZE-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [P_SIZE-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, full;

  logic [A_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [P_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              vld_p1_q, vld_p2_q;
  logic [P_SIZE-1:0] pix_data_p2_q;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign wr_ready = ~full;
  assign push     = wr_req & ~full;
  assign pop      = blanking & (state_q == DRAIN) & (count_q != '0);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (!blanking) begin
      state_d    = SCAN;
      mem_addr_d = scan_addr;
    end else begin
      case (state_q)
        DRAIN: begin
          if (pop) begin
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
            mem_we_d    = 1'b1;
          end
          state_d = (count_d == '0) ? IDLE : DRAIN;
        end
        default: state_d = (count_q != '0) ? DRAIN : IDLE;
      endcase
    end
  end

  // Entry storage carries no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Stage p1: scan qualifier lines up with mem_rdata; stage p2: pixel output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      pix_data_p2_q <= '0;
    end else begin
      vld_p1_q <= ~blanking;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) pix_data_p2_q <= mem_rdata;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign pix_data  = pix_data_p2_q;
  assign pix_valid = vld_p2_q;

`ifdef FB_PORT_ARBITER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else if (wr_req && full) drop_cnt_q <= sat_inc16(drop_cnt_q);
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: expected framebuffer writes queued at push time, checked as they appear.
module tb_fb_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       blanking;
  logic [7:0] scan_addr;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] pix_data;
  logic       pix_valid;
`ifdef FB_PORT_ARBITER_STATS_EN
  logic [15:0] drop_cnt;
`endif

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  fb_port_arbiter #(.A_SIZE(8), .P_SIZE(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blanking  (blanking),
    .scan_addr (scan_addr),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid)
`ifdef FB_PORT_ARBITER_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Every framebuffer write must match the oldest outstanding accepted push.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    blanking  = 1'b1;
    scan_addr = 8'h00;
    wr_req    = 1'b0;
    wr_addr   = 8'h00;
    wr_data   = 8'h00;
    mem_rdata = 8'h00;
    tick();
    tick();
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
`ifdef FB_PORT_ARBITER_STATS_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Three pushes during blanking drain on consecutive cycles.
    push(8'h01, 8'hAA); tick(); chk("t1_we_e0", 32'(mem_we), 32'd0);
    push(8'h02, 8'hBB); tick(); chk("t1_we_e1", 32'(mem_we), 32'd0);
    push(8'h03, 8'hCC); tick(); chk("t1_we_e2", 32'(mem_we), 32'd1);
    wr_req = 1'b0;
    tick(); chk("t1_we_e3", 32'(mem_we), 32'd1);
    tick(); chk("t1_we_e4", 32'(mem_we), 32'd1);
    tick(); chk("t1_we_e5", 32'(mem_we), 32'd0);
    chk("t1_qsize", 32'(exp_q.size()), 32'd0);

    // Scan read: pixel returns two cycles after the scan cycle.
    blanking = 1'b0; scan_addr = 8'h10;
    tick();
    chk("t2_mem_addr", 32'(mem_addr), 32'h10);
    chk("t2_mem_we", 32'(mem_we), 32'd0);
    blanking = 1'b1; mem_rdata = 8'h5A;
    tick();
    chk("t2_pix_valid", 32'(pix_valid), 32'd1);
    chk("t2_pix_data", 32'(pix_data), 32'h5A);
    mem_rdata = 8'h33;
    tick();
    chk("t2_pix_valid_off", 32'(pix_valid), 32'd0);
    chk("t2_pix_data_hold", 32'(pix_data), 32'h5A);

    // Fill during scan, drop an overflow push, then push+pop at count 2.
    blanking = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'h21 + 8'(i), 8'h31 + 8'(i));
      tick();
    end
    chk("t3_full_ready", 32'(wr_ready), 32'd0);
    wr_req = 1'b1; wr_addr = 8'h55; wr_data = 8'h66;
    tick();
    chk("t3_full_ready2", 32'(wr_ready), 32'd0);
`ifdef FB_PORT_ARBITER_STATS_EN
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    wr_req = 1'b0;
    chk("t3_scan_we", 32'(mem_we), 32'd0);
    blanking = 1'b1;
    tick(); chk("t3_we_f0", 32'(mem_we), 32'd0);
    tick(); chk("t3_we_f1", 32'(mem_we), 32'd1);
    chk("t3_ready_f1", 32'(wr_ready), 32'd1);
    tick(); chk("t3_we_f2", 32'(mem_we), 32'd1);
    push(8'h27, 8'h37);
    tick(); chk("t3_we_f3", 32'(mem_we), 32'd1);
    wr_req = 1'b0;
    tick(); chk("t3_we_f4", 32'(mem_we), 32'd1);
    tick(); chk("t3_we_f5", 32'(mem_we), 32'd1);
    tick(); chk("t3_we_f6", 32'(mem_we), 32'd0);
    chk("t3_qsize", 32'(exp_q.size()), 32'd0);

    // Blanking falls with two entries left; they drain in the next interval.
    blanking = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'h41 + 8'(i), 8'h51 + 8'(i));
      tick();
    end
    wr_req = 1'b0;
    blanking = 1'b1;
    tick(); chk("t4_we_h0", 32'(mem_we), 32'd0);
    tick(); chk("t4_we_h1", 32'(mem_we), 32'd1);
    tick(); chk("t4_we_h2", 32'(mem_we), 32'd1);
    blanking = 1'b0;
    tick(); chk("t4_we_preempt", 32'(mem_we), 32'd0);
    tick();
    tick(); chk("t4_retained", 32'(exp_q.size()), 32'd2);
    blanking = 1'b1;
    tick(); chk("t4_we_r0", 32'(mem_we), 32'd0);
    tick(); chk("t4_we_r1", 32'(mem_we), 32'd1);
    tick(); chk("t4_we_r2", 32'(mem_we), 32'd1);
    tick(); chk("t4_we_r3", 32'(mem_we), 32'd0);
    chk("t4_qsize", 32'(exp_q.size()), 32'd0);

    // Reset mid-drain discards entries and clears mem_we without a clock.
    blanking = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(8'h61 + 8'(i), 8'h71 + 8'(i));
      tick();
    end
    wr_req = 1'b0;
    blanking = 1'b1;
    tick(); chk("t5_we_d0", 32'(mem_we), 32'd0);
    tick(); chk("t5_we_d1", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_we", 32'(mem_we), 32'd0);
    chk("t5_async_ready", 32'(wr_ready), 32'd1);
    chk("t5_async_addr", 32'(mem_addr), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t5_no_writes", 32'(mem_we), 32'd0);
    chk("t5_ready_after", 32'(wr_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 The block SHALL have parameter A_SIZE, default 8, framebuffer address width.
REQ-002 The block SHALL have parameter P_SIZE, default 8, pixel data width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries; power of 2, range 2..16.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port blanking, input, 1, display blanking flag from the display timing core.
REQ-007 The block SHALL have port scan_addr, input, A_SIZE, scan-out address from the display timing core.
REQ-008 The block SHALL have port wr_req, input, 1, writer push request.
REQ-009 The block SHALL have port wr_addr, input, A_SIZE, writer address.
REQ-010 The block SHALL have port wr_data, input, P_SIZE, writer pixel data.
REQ-011 The block SHALL have port wr_ready, output, 1, buffer can accept a push; combinational, equal to not-full.
REQ-012 The block SHALL have port mem_addr, output, A_SIZE, registered framebuffer address.
REQ-013 The block SHALL have port mem_we, output, 1, registered framebuffer write enable.
REQ-014 The block SHALL have port mem_wdata, output, P_SIZE, registered framebuffer write data.
REQ-015 The block SHALL have port mem_rdata, input, P_SIZE, framebuffer read data, valid one cycle after mem_addr.
REQ-016 The block SHALL have port pix_data, output, P_SIZE, registered pixel to the display.
REQ-017 The block SHALL have port pix_valid, output, 1, pix_data qualifier.

Function
REQ-018 The block SHALL accept a push on each cycle in which wr_req and wr_ready are both 1; pushes with wr_ready=0 are ignored and not stored.
REQ-019 The block SHALL implement three states: IDLE (blanking=1, buffer empty), SCAN (blanking=0), and DRAIN (blanking=1, buffer non-empty).
REQ-020 Any state SHALL go to SCAN on a cycle with blanking=0, so scan-out preempts draining with zero delay.
REQ-021 SCAN and IDLE SHALL go to DRAIN when blanking=1 and the buffer is non-empty; otherwise they go to IDLE.
REQ-022 DRAIN SHALL go to IDLE on the cycle its final entry pops.
REQ-023 In a SCAN cycle t, the block SHALL set mem_addr<=scan_addr and mem_we<=0, with no pop.
REQ-024 In a DRAIN cycle t, the block SHALL set mem_addr<=head address, mem_wdata<=head data, and mem_we<=1, and pop one entry.
REQ-025 In an IDLE cycle, the block SHALL set mem_we<=0 and hold mem_addr and mem_wdata.
REQ-026 The block SHALL register pix_valid(t+2) = ~blanking(t) and pix_data(t+2) = mem_rdata(t+1); pix_data holds when pix_valid=0. Latency is 2 cycles.
REQ-027 The buffer SHALL be FIFO-ordered; a same-cycle push and pop SHALL leave the count unchanged and be legal at any non-full count.
REQ-028 A push into an empty buffer SHALL be poppable no earlier than the next cycle (no fall-through).
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-030 Entries left over when blanking falls SHALL be retained and drained in the next blanking interval.

Reset
REQ-031 While rst_n=0, the block SHALL hold state=IDLE, buffer empty, wr_ready=1, and mem_addr, mem_we, mem_wdata, pix_data, pix_valid, and the delay pipeline all at 0.
REQ-032 Reset asserted mid-drain SHALL discard all buffered entries, and mem_we SHALL drop to 0 asynchronously.
REQ-033 After rst_n rises, the first state update SHALL occur on the next rising clk edge.

Configuration
REQ-034 With macro FB_PORT_ARBITER_STATS_EN defined, the block SHALL add output drop_cnt[15:0], which increments on each cycle with wr_req=1 and wr_ready=0, saturates at 16'hFFFF, and resets to 0.
REQ-035 Without FB_PORT_ARBITER_STATS_EN, the drop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Push 3 entries (addr 1,2,3; data A,B,C) while blanking=1 -> mem_we=1 on 3 consecutive cycles with addresses 1,2,3 in order, then IDLE.
REQ-037 blanking falls while 2 of 4 entries remain -> mem_we=0 the next cycle; the remaining 2 entries are written after blanking rises, in order.
REQ-038 blanking=0 with scan_addr=0x10 at cycle t and mem_rdata=0x5A at t+1 -> pix_data=0x5A and pix_valid=1 at t+2.
REQ-039 4 pushes with blanking=0 -> wr_ready=0; a 5th push is ignored (drop_cnt=1 when FB_PORT_ARBITER_STATS_EN is defined); simultaneous push and pop at count 2 -> count stays 2.
REQ-040 Assert rst_n=0 mid-drain with 3 entries -> mem_we=0 immediately and wr_ready=1; no writes occur after release.
